// File: rtl/vec_mac_cfu_pkg.sv
// Shared opcodes, FSM states, command struct and LMUL decode helpers for vec_mac_cfu.
package vec_mac_cfu_pkg;

   typedef enum logic [2:0] {
      OP_VSETVL = 3'd0,
      OP_VWRITE = 3'd1,
      OP_VMAC   = 3'd2,
      OP_ACCRD  = 3'd3,
      OP_SETOFS = 3'd4
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] in0;
      logic [31:0] in1;
   } cmd_t;

   localparam int LMUL_LOG2_W = 2;
   localparam int LMUL_CNT_W  = 3;
   localparam int OFS_W       = 9;
   // int8 element plus 9-bit offset needs 10 bits; times int8 fits in 18
   localparam int MUL_A_W     = 10;
   localparam int PROD_W      = 18;

   function automatic logic [LMUL_CNT_W-1:0] lmul_last(input logic [LMUL_LOG2_W-1:0] l);
      return LMUL_CNT_W'((4'd1 << l) - 4'd1);
   endfunction

endpackage

// File: rtl/vec_mac_cfu_dot8.sv
// vec_dot8: combinational signed int8 dot product across one vector register pair,
// with an optional signed offset added to every element of operand a.
module vec_dot8
   import vec_mac_cfu_pkg::*;
#(
   parameter int VLEN = 256
) (
   input  logic [VLEN-1:0]         vec_a,
   input  logic [VLEN-1:0]         vec_b,
   input  logic signed [OFS_W-1:0] ofs,
   output logic [31:0]             dot
);

   localparam int NUM_LANES = VLEN / 8;

   logic [NUM_LANES-1:0][PROD_W-1:0] prod;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic signed [MUL_A_W-1:0] mul_a;
      logic signed [7:0]         mul_b;
      assign mul_a   = MUL_A_W'($signed(vec_a[i*8 +: 8])) + MUL_A_W'(ofs);
      assign mul_b   = $signed(vec_b[i*8 +: 8]);
      assign prod[i] = PROD_W'(mul_a) * PROD_W'(mul_b);
   end

   always_comb begin
      dot = '0;
      for (int i = 0; i < NUM_LANES; i++) dot = dot + 32'($signed(prod[i]));
   end

endmodule

// File: rtl/vec_mac_cfu.sv
// Vector MAC custom function unit: int8 vector register file, LMUL-grouped dot-product
// accumulate. Define VEC_MAC_CFU_INPUT_OFFSET_EN to enable the SETOFS input offset.
module vec_mac_cfu
   import vec_mac_cfu_pkg::*;
#(
   parameter int VLEN          = 256,
   parameter int NUM_VREGS     = 32,
   parameter int MAX_LMUL_LOG2 = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_payload_function_id,
   input  logic [31:0] cmd_payload_inputs_0,
   input  logic [31:0] cmd_payload_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_payload_outputs_0
);

   localparam int WORDS  = VLEN / 32;
   localparam int WORD_W = $clog2(WORDS);
   localparam int VIDX_W = $clog2(NUM_VREGS);

   cmd_t                   cmd;
   state_e                 state_q, state_d;
   logic [31:0]            acc_q, acc_d, rsp_q, rsp_d, dot;
   logic [LMUL_LOG2_W-1:0] lmul_q, lmul_d, lmul_req;
   logic [VIDX_W-1:0]      rs1_q, rs1_d, rs2_q, rs2_d, wr_vi;
   logic [WORD_W-1:0]      wr_wi;
   logic [LMUL_CNT_W-1:0]  cnt_q, cnt_d;
   logic                   wr_en, accept;
   logic                   unused_bits;
   logic [VLEN-1:0]        vreg [NUM_VREGS];

   assign cmd         = '{op: cmd_payload_function_id[2:0], in0: cmd_payload_inputs_0,
                          in1: cmd_payload_inputs_1};
   assign unused_bits = ^{cmd_payload_function_id[9:3], cmd.in0};

   assign cmd_ready             = (state_q == ST_IDLE);
   assign accept                = cmd_valid && cmd_ready;
   assign rsp_valid             = (state_q == ST_RESP);
   assign rsp_payload_outputs_0 = rsp_q;

   assign lmul_req = (cmd.in0[1:0] > LMUL_LOG2_W'(MAX_LMUL_LOG2)) ?
                     LMUL_LOG2_W'(MAX_LMUL_LOG2) : cmd.in0[1:0];
   assign wr_vi    = cmd.in0[VIDX_W-1:0];
   assign wr_wi    = WORD_W'(cmd.in0[15:8] % WORDS);

`ifdef VEC_MAC_CFU_INPUT_OFFSET_EN
   logic signed [OFS_W-1:0] ofs_q;
   always_ff @(posedge clk) begin
      if (reset) ofs_q <= '0;
      else if (accept && cmd.op == OP_SETOFS) ofs_q <= cmd.in0[OFS_W-1:0];
   end
`else
   logic signed [OFS_W-1:0] ofs_q;
   assign ofs_q = '0;
`endif

   // Register file has no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (wr_en) vreg[wr_vi][wr_wi*32 +: 32] <= cmd.in1;
   end

   vec_dot8 #(.VLEN(VLEN)) u_dot (
      .vec_a (vreg[rs1_q]),
      .vec_b (vreg[rs2_q]),
      .ofs   (ofs_q),
      .dot   (dot)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rsp_d   = rsp_q;
      lmul_d  = lmul_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE: if (cmd_valid) begin
            state_d = ST_RESP;
            rsp_d   = '0;
            case (cmd.op)
               OP_VSETVL: begin
                  lmul_d = lmul_req;
                  rsp_d  = 32'(VLEN / 8) << lmul_req;
               end
               OP_VWRITE: wr_en = 1'b1;
               OP_VMAC: begin
                  state_d = ST_BUSY;
                  rs1_d   = cmd.in0[VIDX_W-1:0];
                  rs2_d   = cmd.in1[VIDX_W-1:0];
                  cnt_d   = '0;
               end
               OP_ACCRD: begin
                  rsp_d = acc_q;
                  if (cmd.in0[0]) acc_d = '0;
               end
               default: ;
            endcase
         end
         // One register pair per cycle; indices wrap naturally at NUM_VREGS.
         ST_BUSY: begin
            acc_d = acc_q + dot;
            rs1_d = rs1_q + VIDX_W'(1);
            rs2_d = rs2_q + VIDX_W'(1);
            cnt_d = cnt_q + LMUL_CNT_W'(1);
            if (cnt_q == lmul_last(lmul_q)) begin
               state_d = ST_RESP;
               rsp_d   = acc_q + dot;
            end
         end
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         rsp_q  <= '0;
         lmul_q <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         cnt_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         rsp_q  <= rsp_d;
         lmul_q <= lmul_d;
         rs1_q  <= rs1_d;
         rs2_q  <= rs2_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_vec_mac_cfu.sv
// Randomized bench for vec_mac_cfu against a byte-array reference model.
module tb_vec_mac_cfu;

   localparam int VLEN = 256, NV = 32, NB = VLEN / 8, NW = VLEN / 32;
   localparam logic [2:0] C_VSETVL = 3'd0, C_VWRITE = 3'd1, C_VMAC = 3'd2,
                          C_ACCRD = 3'd3, C_SETOFS = 3'd4;

   logic        clk = 1'b0, reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
   logic [9:0]  fid = '0;
   logic [31:0] in0 = '0, in1 = '0, rsp_data;
   logic        cmd_valid2 = 1'b0, cmd_ready2, rsp_valid2, rsp_ready2 = 1'b0;
   logic [31:0] rsp_data2;

   always #5 clk = ~clk;

   vec_mac_cfu #(.VLEN(VLEN), .NUM_VREGS(NV), .MAX_LMUL_LOG2(3)) u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_data));

   vec_mac_cfu #(.VLEN(256), .NUM_VREGS(8), .MAX_LMUL_LOG2(1)) u_dut_m1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_payload_outputs_0(rsp_data2));

   byte mv [NV][NB];
   int  m_acc = 0, m_lmul = 0, m_ofs = 0;
   int  n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void m_write(input logic [31:0] a, input logic [31:0] d);
      int vi = int'(a[4:0]);
      int wi = int'(a[15:8]) % NW;
      for (int j = 0; j < 4; j++) mv[vi][wi*4 + j] = d[j*8 +: 8];
   endfunction

   function automatic int m_vmac(input int rs1, input int rs2);
      int acc = m_acc;
      for (int k = 0; k < (1 << m_lmul); k++)
         for (int e = 0; e < NB; e++)
            acc += (int'(mv[(rs1 + k) % NV][e]) + m_ofs) * int'(mv[(rs2 + k) % NV][e]);
      return acc;
   endfunction

   task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      int n = 0;
      @(negedge clk);
      fid = {7'($urandom), op}; in0 = a; in1 = b; cmd_valid = 1'b1;
      while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
      chk("cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1 cmd_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 40);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      res = rsp_data;
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
   endtask

   task automatic op_chk(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int lat;
      do_cmd(op, a, b, res, lat);
      chk(tag, res, exp);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic vsetvl(input logic [31:0] a);
      int lm = (int'(a[1:0]) > 3) ? 3 : int'(a[1:0]);
      m_lmul = lm;
      op_chk("vsetvl", C_VSETVL, a, $urandom, 32'(NB << lm), 1);
   endtask

   task automatic vwrite(input logic [31:0] a, input logic [31:0] d);
      m_write(a, d);
      op_chk("vwrite", C_VWRITE, a, d, 32'd0, 1);
   endtask

   task automatic accrd(input bit clr);
      logic [31:0] a = $urandom;
      a[0] = clr;
      op_chk("accrd", C_ACCRD, a, $urandom, 32'(m_acc), 1);
      if (clr) m_acc = 0;
   endtask

   task automatic vmac(input logic [31:0] a, input logic [31:0] b);
      m_acc = m_vmac(int'(a[4:0]), int'(b[4:0]));
      op_chk("vmac", C_VMAC, a, b, 32'(m_acc), (1 << m_lmul) + 1);
   endtask

   task automatic fill_reg(input int vi, input logic [7:0] bval);
      for (int w = 0; w < NW; w++) begin
         logic [31:0] a = $urandom;
         a[4:0] = 5'(vi); a[15:8] = 8'(w);
         vwrite(a, {4{bval}});
      end
   endtask

   initial begin
      logic [31:0] a, b, exp36;
      bit seen;
      int sel;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_payload", rsp_data, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid2", 32'(rsp_valid), 32'd0);

      // VSETVL, incl. clamp on the MAX_LMUL_LOG2=1 instance
      vsetvl(32'd2);
      vsetvl(32'h0000_0007);
      vsetvl(32'd0);
      @(negedge clk);
      chk("m1_cmd_ready", 32'(cmd_ready2), 32'd1);
      fid = 10'd0; in0 = 32'd3; cmd_valid2 = 1'b1;
      @(posedge clk); #1 cmd_valid2 = 1'b0;
      @(negedge clk);
      chk("m1_rsp_valid", 32'(rsp_valid2), 32'd1);
      chk("m1_vsetvl", rsp_data2, 32'd64);
      rsp_ready2 = 1'b1;
      @(posedge clk); #1 rsp_ready2 = 1'b0;

      // 2 * -1 over 32 elements
      fill_reg(0, 8'h02);
      fill_reg(1, 8'hFF);
      accrd(1'b1);
      m_acc = m_vmac(0, 1);
      op_chk("vmac_basic", C_VMAC, 32'd0, 32'd1, 32'hFFFF_FFC0, 2);
      m_acc = -64;

      // randomize the whole register file, then mixed random traffic
      for (int v = 0; v < NV; v++)
         for (int w = 0; w < NW; w++) begin
            a = $urandom; a[4:0] = 5'(v); a[15:8] = 8'(w);
            vwrite(a, $urandom);
         end
      for (int it = 0; it < 60; it++) begin
         sel = $urandom_range(0, 9);
         a = $urandom; b = $urandom;
         if (sel < 2)      vsetvl(a);
         else if (sel < 4) vwrite(a, b);
         else if (sel < 7) vmac(a, b);
         else if (sel == 7) accrd(a[0]);
         else if (sel == 8) begin
            logic [2:0] op = 3'($urandom_range(4, 7));
`ifdef VEC_MAC_CFU_INPUT_OFFSET_EN
            if (op == C_SETOFS) m_ofs = int'($signed(a[8:0]));
`endif
            op_chk("op_misc", op, a, b, 32'd0, 1);
         end
         else accrd(1'b0);
      end
      accrd(1'b0);

      // LMUL=4 group wrapping past the last register
      vsetvl(32'd2);
      vmac(32'd30, 32'd31);

      // offset feature: 0x80 + 128 = 0 with offset, -128 * 1 * 32 without
      fill_reg(0, 8'h80);
      fill_reg(1, 8'h01);
      op_chk("setofs", C_SETOFS, 32'd128, 32'd0, 32'd0, 1);
`ifdef VEC_MAC_CFU_INPUT_OFFSET_EN
      m_ofs = 128;
      exp36 = 32'd0;
`else
      exp36 = 32'hFFFF_F000;
`endif
      vsetvl(32'd0);
      accrd(1'b1);
      m_acc = m_vmac(0, 1);
      op_chk("vmac_ofs", C_VMAC, 32'd0, 32'd1, exp36, 2);
      m_acc = int'(exp36);

      // response stall with a rejected command pulse
      @(negedge clk);
      fid = {7'd0, C_VSETVL}; in0 = 32'd1; cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
      m_lmul = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_data", rsp_data, 32'd64);
         chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
         if (i == 4) begin fid = {7'd0, C_ACCRD}; in0 = 32'd1; cmd_valid = 1'b1; end
         if (i == 6) cmd_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("stall_no_extra_rsp", 32'(rsp_valid), 32'd0);
      accrd(1'b0);

      // reset during the second BUSY cycle of an LMUL=8 VMAC
      vsetvl(32'd3);
      @(negedge clk);
      fid = {7'd0, C_VMAC}; in0 = 32'd4; in1 = 32'd9; cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("abandoned_rsp", 32'(seen), 32'd0);
      m_acc = 0; m_lmul = 0; m_ofs = 0;
      accrd(1'b0);
      vmac(32'd5, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
